// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: fixed-priority SDRAM arbiter for CPU, DMA and video requesters.
// Define RAM_ARBITER_REFRESH_EN to add the periodic refresh scheduler.
module ram_access_arbiter #(
  parameter logic [15:0] REFRESH_INTERVAL = 16'd780
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  request,
  input  logic [2:0]  write,
  input  logic [59:0] address,
  input  logic [23:0] write_data,
  output logic [2:0]  acknowledge,
  output logic [7:0]  read_data,
  output logic        ram_request,
  output logic        ram_write,
  output logic [19:0] ram_address,
  output logic [7:0]  ram_write_data,
  output logic        ram_refresh,
  input  logic        ram_acknowledge,
  input  logic [7:0]  ram_read_data,
  output logic        refresh_overrun
);
`ifdef RAM_ARBITER_REFRESH_EN
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, REFRESH} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
`endif
  state_t state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic ram_write_q, ram_write_d;
  logic [19:0] ram_address_q, ram_address_d;
  logic [7:0] ram_write_data_q, ram_write_data_d, read_data_q, read_data_d;
`ifdef RAM_ARBITER_REFRESH_EN
  logic [15:0] count_q, count_d;
  logic pend_q, pend_d, overrun_q, overrun_d, expire;
  logic unused_write;
  // An expiry coinciding with the refresh acknowledge keeps pending set.
  always_comb begin
    expire = count_q == 16'd0;
    count_d = expire ? REFRESH_INTERVAL - 16'd1 : count_q - 16'd1;
    pend_d = expire | (pend_q & !(state_q == REFRESH && ram_acknowledge));
    overrun_d = overrun_q | (expire & pend_q);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= REFRESH_INTERVAL - 16'd1;
      pend_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      count_q <= count_d;
      pend_q <= pend_d;
      overrun_q <= overrun_d;
    end
  end
  assign ram_refresh = state_q == REFRESH;
  assign refresh_overrun = overrun_q;
  assign unused_write = write[2];
`else
  logic unused_cfg;
  assign unused_cfg = ^{write[2], REFRESH_INTERVAL};
  assign ram_refresh = 1'b0;
  assign refresh_overrun = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ram_write_d = ram_write_q;
    ram_address_d = ram_address_q;
    ram_write_data_d = ram_write_data_q;
    read_data_d = read_data_q;
    case (state_q)
      IDLE: begin
`ifdef RAM_ARBITER_REFRESH_EN
        if (pend_q) state_d = REFRESH; else
`endif
        if (|request) begin
          state_d = ACCESS;
          grant_d = request[2] ? 3'b100 : request[1] ? 3'b010 : 3'b001;
          ram_address_d = request[2] ? address[59:40] : request[1] ? address[39:20] : address[19:0];
          ram_write_data_d = request[2] ? write_data[23:16] : request[1] ? write_data[15:8] : write_data[7:0];
          ram_write_d = !request[2] && (request[1] ? write[1] : write[0]);
        end
      end
      ACCESS: if (ram_acknowledge) begin
        state_d = DONE;
        read_data_d = ram_read_data;
      end
      DONE: state_d = IDLE;
`ifdef RAM_ARBITER_REFRESH_EN
      REFRESH: state_d = ram_acknowledge ? IDLE : REFRESH;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      ram_write_q <= 1'b0;
      ram_address_q <= 20'h0;
      ram_write_data_q <= 8'h0;
      read_data_q <= 8'h0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ram_write_q <= ram_write_d;
      ram_address_q <= ram_address_d;
      ram_write_data_q <= ram_write_data_d;
      read_data_q <= read_data_d;
    end
  end
  assign acknowledge = state_q == DONE ? grant_q : 3'b000;
  assign ram_request = state_q == ACCESS;
  assign ram_write = ram_write_q;
  assign ram_address = ram_address_q;
  assign ram_write_data = ram_write_data_q;
  assign read_data = read_data_q;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed checks of arbitration, handshake, reset and refresh.
module tb_ram_access_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  logic [2:0] request = 3'b0, write = 3'b0, acknowledge;
  logic [59:0] address = 60'h0;
  logic [23:0] write_data = 24'h0;
  logic [7:0] read_data, ram_write_data, ram_read_data = 8'h0;
  logic [19:0] ram_address;
  logic ram_request, ram_write, ram_refresh, ram_acknowledge = 1'b0, refresh_overrun;
  int vectors = 0, miscompares = 0;
  ram_access_arbiter #(.REFRESH_INTERVAL(16'd10)) dut (
    .clock(clock), .reset(reset), .request(request), .write(write), .address(address),
    .write_data(write_data), .acknowledge(acknowledge), .read_data(read_data),
    .ram_request(ram_request), .ram_write(ram_write), .ram_address(ram_address),
    .ram_write_data(ram_write_data), .ram_refresh(ram_refresh),
    .ram_acknowledge(ram_acknowledge), .ram_read_data(ram_read_data),
    .refresh_overrun(refresh_overrun)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [42:0] all_out();
    return {acknowledge, read_data, ram_request, ram_write, ram_address, ram_write_data, ram_refresh, refresh_overrun};
  endfunction
  initial begin
    logic [2:0] g;
    tick();
    tick();
    chk("reset_outputs", all_out(), 43'h0);
    reset = 1'b0;
`ifdef RAM_ARBITER_REFRESH_EN
    repeat (10) tick();
    chk("refresh_before_first", ram_refresh, 1'b0);
    tick();
    chk("refresh_first", ram_refresh, 1'b1);
    chk("refresh_no_request", ram_request, 1'b0);
    ram_acknowledge = 1'b1;
    tick();
    ram_acknowledge = 1'b0;
    chk("refresh_first_done", ram_refresh, 1'b0);
    repeat (8) tick();
    chk("refresh_before_second", ram_refresh, 1'b0);
    request = 3'b001;
    address = 60'h00000_00000_12345;
    tick();
    chk("refresh_beats_cpu", {ram_refresh, ram_request}, 2'b10);
    ram_acknowledge = 1'b1;
    tick();
    ram_acknowledge = 1'b0;
    chk("refresh_second_done", {ram_refresh, ram_request}, 2'b00);
    tick();
    chk("cpu_after_refresh", {ram_refresh, ram_request, ram_address}, {2'b01, 20'h12345});
    ram_acknowledge = 1'b1;
    tick();
    chk("cpu_ack_after_refresh", acknowledge, 3'b001);
    request = 3'b000;
    ram_acknowledge = 1'b0;
    tick();
    repeat (6) tick();
    chk("refresh_third", ram_refresh, 1'b1);
    repeat (8) tick();
    chk("overrun_not_yet", {ram_refresh, refresh_overrun}, 2'b10);
    tick();
    chk("overrun_set", refresh_overrun, 1'b1);
    ram_acknowledge = 1'b1;
    tick();
    ram_acknowledge = 1'b0;
    chk("overrun_sticky_idle", {ram_refresh, refresh_overrun}, 2'b01);
    repeat (3) tick();
    chk("overrun_sticky_later", refresh_overrun, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("overrun_cleared_by_reset", all_out(), 43'h0);
`else
    request = 3'b001;
    write = 3'b001;
    address = 60'h00000_00000_789AB;
    write_data = 24'h0000CD;
    tick();
    chk("cpu_wr_access", {ram_request, ram_write, ram_address, ram_write_data}, {2'b11, 20'h789AB, 8'hCD});
    chk("cpu_wr_no_ack", acknowledge, 3'b000);
    request = 3'b000;
    address = 60'h0;
    write_data = 24'h0;
    tick();
    chk("cpu_wr_hold", {ram_request, ram_write, ram_address, ram_write_data}, {2'b11, 20'h789AB, 8'hCD});
    ram_acknowledge = 1'b1;
    tick();
    ram_acknowledge = 1'b0;
    chk("cpu_wr_done", {acknowledge, ram_request}, {3'b001, 1'b0});
    tick();
    chk("cpu_wr_ack_one_cycle", {acknowledge, ram_request}, 4'b0);
    request = 3'b111;
    write = 3'b000;
    address = 60'h33333_22222_11111;
    g = 3'b100;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("prio_access_%0d", k), {ram_request, ram_address},
          {1'b1, k == 0 ? 20'h33333 : k == 1 ? 20'h22222 : 20'h11111});
      ram_acknowledge = 1'b1;
      ram_read_data = 8'hA0 + 8'(k);
      tick();
      ram_acknowledge = 1'b0;
      ram_read_data = 8'h00;
      chk($sformatf("prio_ack_%0d", k), {acknowledge, ram_request, read_data}, {g, 1'b0, 8'hA0 + 8'(k)});
      request = request & ~g;
      tick();
      chk($sformatf("prio_gap_%0d", k), {acknowledge, ram_request}, 4'b0);
      g = g >> 1;
    end
    tick();
    chk("prio_idle_after", {acknowledge, ram_request}, 4'b0);
    request = 3'b100;
    write = 3'b100;
    address = 60'hB8000_00000_00000;
    tick();
    chk("video_access", {ram_request, ram_write, ram_address}, {2'b10, 20'hB8000});
    request = 3'b000;
    ram_acknowledge = 1'b1;
    ram_read_data = 8'h5A;
    tick();
    ram_acknowledge = 1'b0;
    ram_read_data = 8'h00;
    chk("video_read", {acknowledge, read_data}, {3'b100, 8'h5A});
    tick();
    ram_acknowledge = 1'b1;
    tick();
    ram_acknowledge = 1'b0;
    chk("stray_ram_ack_idle", {acknowledge, ram_request}, 4'b0);
    request = 3'b010;
    write = 3'b010;
    address = 60'h00000_2ABCD_00000;
    write_data = 24'h007700;
    tick();
    chk("dma_wr_access", {ram_request, ram_write, ram_address, ram_write_data}, {2'b11, 20'h2ABCD, 8'h77});
    request = 3'b000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid_access", all_out(), 43'h0);
    ram_acknowledge = 1'b1;
    tick();
    ram_acknowledge = 1'b0;
    chk("abandoned_no_ack", {acknowledge, ram_request}, 4'b0);
    repeat (30) tick();
    chk("no_refresh_without_macro", {ram_refresh, refresh_overrun, ram_request}, 3'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
